// File: rtl/mux3_arb_pkg.sv
// Shared types and helpers for the 3-source select arbiter (see mux3_rr_arbiter).
// The MUX3_ARB_PRIO_EN option is handled in the top; nothing here depends on it.
package mux3_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Source index; only 0..2 are legal.
  typedef logic [1:0] src_t;

  localparam src_t SRC_A0 = 2'd0;
  localparam src_t SRC_A1 = 2'd1;
  localparam src_t SRC_A2 = 2'd2;

  // {sl1, sl0} for each source; 2'b11 is never driven.
  localparam logic [1:0] SEL_A0 = 2'b00;
  localparam logic [1:0] SEL_A1 = 2'b01;
  localparam logic [1:0] SEL_A2 = 2'b10;

  function automatic src_t src_inc(input src_t s);
    return (s == SRC_A2) ? SRC_A0 : src_t'(s + 2'd1);
  endfunction

  function automatic logic [2:0] src_onehot(input src_t s);
    return 3'(3'b001 << s);
  endfunction

  function automatic logic [1:0] src_sel(input src_t s);
    case (s)
      SRC_A1:  return SEL_A1;
      SRC_A2:  return SEL_A2;
      default: return SEL_A0;
    endcase
  endfunction

endpackage

// File: rtl/mux3_rr_pick.sv
// Combinational rotate-priority picker: first set request scanning upward
// from rr_ptr, wrapping modulo 3.
module mux3_rr_pick
  import mux3_arb_pkg::*;
(
  input  logic [2:0] req,
  input  src_t       rr_ptr,
  output logic [2:0] onehot,
  output src_t       idx,
  output logic       any
);

  src_t p0;
  src_t p1;
  src_t p2;

  assign p0  = rr_ptr;
  assign p1  = src_inc(p0);
  assign p2  = src_inc(p1);
  assign any = |req;

  always_comb begin
    idx = p0;
    if (req[p0]) begin
      idx = p0;
    end else if (req[p1]) begin
      idx = p1;
    end else if (req[p2]) begin
      idx = p2;
    end
    onehot = any ? src_onehot(idx) : 3'b000;
  end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter with burst lock driving the 3:1 mux selects (sl1/sl0) and a one-hot grant.
// Define MUX3_ARB_PRIO_EN to give source A2 strict priority over A0/A1.
module mux3_rr_arbiter
  import mux3_arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [2:0]       req,
  input  logic [2:0]       last,
  input  logic             ds_ready,
  output logic [2:0]       gnt,
  output logic             sl0,
  output logic             sl1,
  output logic             out_valid,
  output logic [CNT_W-1:0] beat_cnt,
  output state_t           fsm_state
);

  state_t           state_q, state_d;
  src_t             g_q, g_d;
  src_t             rr_q, rr_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic             granted;
  logic             accept;
  logic             burst_end;
  logic             release_now;
  logic [2:0]       cand;
  logic [2:0]       pick_req;
  src_t             pick_ptr;
  logic [2:0]       pick_oh;
  src_t             pick_idx;
  logic             pick_any;
  logic [2:0]       win_oh;
  src_t             win_idx;
  logic             win_any;

  // Handshake: a beat transfers on a cycle where out_valid && ds_ready;
  // out_valid follows the granted source's req, and nothing advances while ds_ready is low.
  assign granted     = (state_q == GRANT);
  assign out_valid   = granted && req[g_q];
  assign accept      = out_valid && ds_ready;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign burst_end   = last[g_q] || (cnt_inc == CNT_W'(BURST_MAX));
  assign release_now = granted && (!req[g_q] || (accept && burst_end));

  // On release the current holder is excluded and the scan starts just past it.
  assign cand     = granted ? (req & ~gnt_q) : req;
  assign pick_ptr = granted ? src_inc(g_q) : rr_q;

`ifdef MUX3_ARB_PRIO_EN
  assign pick_req = cand & 3'b011;
  assign win_any  = req[2] || pick_any;
  assign win_idx  = req[2] ? SRC_A2 : pick_idx;
  assign win_oh   = req[2] ? 3'b100 : pick_oh;
`else
  assign pick_req = cand;
  assign win_any  = pick_any;
  assign win_idx  = pick_idx;
  assign win_oh   = pick_oh;
`endif

  mux3_rr_pick u_pick (
    .req    (pick_req),
    .rr_ptr (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = GRANT;
          g_d     = win_idx;
          gnt_d   = win_oh;
          sel_d   = src_sel(win_idx);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          rr_d  = src_inc(g_q);
          cnt_d = '0;
          if (win_any) begin
            g_d   = win_idx;
            gnt_d = win_oh;
            sel_d = src_sel(win_idx);
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
          end
        end else if (accept) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      g_q     <= SRC_A0;
      rr_q    <= SRC_A0;
      gnt_q   <= 3'b000;
      sel_q   <= SEL_A0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sl1       = sel_q[1];
  assign sl0       = sel_q[0];
  assign beat_cnt  = cnt_q;
  assign fsm_state = state_q;

  a_gnt_onehot0 : assert property (@(posedge CK) disable iff (!RN) $onehot0(gnt_q));
  a_sel_legal   : assert property (@(posedge CK) disable iff (!RN) sel_q != 2'b11);
  a_ptr_legal   : assert property (@(posedge CK) disable iff (!RN) rr_q != 2'd3);

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a source-index level model.
module tb_mux3_rr_arbiter;
  import mux3_arb_pkg::*;

  localparam int BURST_MAX = 4;
  localparam int CNT_W     = 3;

  logic             CK;
  logic             RN;
  logic [2:0]       req;
  logic [2:0]       last;
  logic             ds_ready;
  logic [2:0]       gnt;
  logic             sl0;
  logic             sl1;
  logic             out_valid;
  logic [CNT_W-1:0] beat_cnt;
  state_t           fsm_state;

  int total;
  int bad;

  // Model: owner is the granted source (-1 when idle), sel the last select index.
  int m_owner;
  int m_cnt;
  int m_ptr;
  int m_sel;

  logic [4:0] exp_q[$];

  mux3_rr_arbiter #(.BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
    .CK        (CK),
    .RN        (RN),
    .req       (req),
    .last      (last),
    .ds_ready  (ds_ready),
    .gnt       (gnt),
    .sl0       (sl0),
    .sl1       (sl1),
    .out_valid (out_valid),
    .beat_cnt  (beat_cnt),
    .fsm_state (fsm_state)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [2:0] r, input int start, input int skip);
`ifdef MUX3_ARB_PRIO_EN
    if (r[2]) return 2;
`endif
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (start + k) % 3;
`ifdef MUX3_ARB_PRIO_EN
      if (i == 2) continue;
`endif
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] l, input logic d);
    int w;
    bit rel;
    rel = 1'b0;
    if (m_owner < 0) begin
      w = model_pick(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_cnt   = 0;
      end
    end else begin
      if (!r[m_owner]) begin
        rel = 1'b1;
      end else if (d) begin
        m_cnt = m_cnt + 1;
        rel   = l[m_owner] || (m_cnt == BURST_MAX);
      end
      if (rel) begin
        m_ptr = (m_owner + 1) % 3;
        m_cnt = 0;
        w = model_pick(r, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w;
          m_sel   = w;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [2:0] eg;
    logic       eov;
    eg  = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    eov = (m_owner >= 0) ? req[m_owner] : 1'b0;
    chk("gnt", 8'(gnt), 8'(eg));
    chk("sel", 8'({sl1, sl0}), 8'(m_sel));
    chk("out_valid", 8'(out_valid), 8'(eov));
    chk("beat_cnt", 8'(beat_cnt), 8'(m_cnt));
    chk("state", 8'(fsm_state), (m_owner >= 0) ? 8'(GRANT) : 8'(IDLE));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic rn_v, input logic [2:0] r, input logic [2:0] l, input logic d);
    RN       = rn_v;
    req      = r;
    last     = l;
    ds_ready = d;
    if (!rn_v) model_reset();
    #1;
    compare_model();
    @(posedge CK);
    if (rn_v) model_step(r, l, d);
    @(negedge CK);
  endtask

  task automatic apply_reset();
    cycle(1'b0, 3'b000, 3'b000, 1'b0);
  endtask

  initial begin
    logic [4:0] e;
    logic [2:0] r_hold;
    logic [2:0] exp_gnt_seq [6];
    int         exp_cnt_seq [6];

    total    = 0;
    bad      = 0;
    RN       = 1'b0;
    req      = 3'b000;
    last     = 3'b000;
    ds_ready = 1'b0;
    model_reset();
    @(negedge CK);

    // Reset with all requests up, then first grant one edge after release.
    cycle(1'b0, 3'b111, 3'b111, 1'b1);
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_sel", 8'({sl1, sl0}), 8'h00);
    chk("rst_out_valid", 8'(out_valid), 8'h00);
    chk("rst_beat_cnt", 8'(beat_cnt), 8'h00);

`ifdef MUX3_ARB_PRIO_EN
    for (int n = 0; n < 4; n++) exp_q.push_back({3'b100, 2'b10});
`else
    exp_q.push_back({3'b001, 2'b00});
    exp_q.push_back({3'b010, 2'b01});
    exp_q.push_back({3'b100, 2'b10});
    exp_q.push_back({3'b001, 2'b00});
`endif
    for (int n = 0; n < 4; n++) begin
      cycle(1'b1, 3'b111, 3'b111, 1'b1);
      e = exp_q.pop_front();
      chk("rr_seq", 8'({gnt, sl1, sl0}), 8'(e));
    end

    // Burst cap on a lone requester, then regrant after one idle cycle.
    apply_reset();
    exp_gnt_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001};
    exp_cnt_seq = '{0, 1, 2, 3, 0, 0};
    for (int n = 0; n < 6; n++) begin
      cycle(1'b1, 3'b001, 3'b000, 1'b1);
      chk("burst_gnt", 8'(gnt), 8'(exp_gnt_seq[n]));
      chk("burst_cnt", 8'(beat_cnt), 8'(exp_cnt_seq[n]));
    end

    // Stall mid-burst: everything frozen, then counting resumes.
    cycle(1'b1, 3'b001, 3'b000, 1'b1);
    chk("stall_pre_cnt", 8'(beat_cnt), 8'h01);
    for (int n = 0; n < 5; n++) begin
      cycle(1'b1, 3'b001, 3'b000, 1'b0);
      chk("stall_gnt", 8'(gnt), 8'h01);
      chk("stall_cnt", 8'(beat_cnt), 8'h01);
      chk("stall_sel", 8'({sl1, sl0}), 8'h00);
    end
    cycle(1'b1, 3'b001, 3'b000, 1'b1);
    chk("stall_resume_cnt", 8'(beat_cnt), 8'h02);

    // Abort: A1 drops after two beats while A2 waits.
    apply_reset();
    for (int n = 0; n < 3; n++) cycle(1'b1, 3'b010, 3'b000, 1'b1);
    chk("abort_pre_gnt", 8'(gnt), 8'h02);
    chk("abort_pre_cnt", 8'(beat_cnt), 8'h02);
    cycle(1'b1, 3'b100, 3'b000, 1'b1);
    chk("abort_gnt", 8'(gnt), 8'h04);
    chk("abort_sel", 8'({sl1, sl0}), 8'h02);
    chk("abort_cnt", 8'(beat_cnt), 8'h00);
    cycle(1'b1, 3'b100, 3'b000, 1'b1);
    chk("abort_next_cnt", 8'(beat_cnt), 8'h01);

    // Reset asserted mid-burst clears everything immediately.
    cycle(1'b0, 3'b100, 3'b000, 1'b1);
    chk("midrst_gnt", 8'(gnt), 8'h00);
    chk("midrst_cnt", 8'(beat_cnt), 8'h00);
    chk("midrst_sel", 8'({sl1, sl0}), 8'h00);

`ifdef MUX3_ARB_PRIO_EN
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      cycle(1'b1, 3'b101, 3'b101, 1'b1);
      chk("prio_gnt", 8'(gnt), 8'h04);
    end
    cycle(1'b1, 3'b001, 3'b101, 1'b1);
    chk("prio_a0_gnt", 8'(gnt), 8'h01);
`endif

    // Randomized traffic with occasional asynchronous resets.
    apply_reset();
    r_hold = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      logic       rn_v;
      logic [2:0] l_v;
      logic       d_v;
      if ($urandom_range(0, 5) == 0) r_hold = 3'($urandom_range(0, 7));
      rn_v = ($urandom_range(0, 99) != 0);
      l_v  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      d_v  = ($urandom_range(0, 3) != 0);
      cycle(rn_v, r_hold, l_v, d_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
